// File: rtl/led_blink_queue.sv
// Queues rising edges of evt_in and plays one fixed-length LED blink per queued
// event, with a guaranteed dark gap after every blink.
module led_blink_queue #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 25_000_000,
  parameter int PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evt_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  // state    | meaning
  // ST_IDLE  | LED dark, queue empty, waiting for a pending event
  // ST_ON    | LED lit, timer counting down the on time
  // ST_GAP   | LED dark, timer counting down the mandatory gap
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0]  PEND_MAX = '1;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [PEND_W-1:0]  pending_q, pending_d;
  logic               evt_q_q, evt_q_d;
  logic               overflow_q, overflow_d;
  logic               evt_edge;
  logic               start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      pending_q  <= '0;
      evt_q_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      evt_q_q    <= evt_q_d;
      overflow_q <= overflow_d;
    end
  end

  // Blink sequencer; start marks the cycle a queued event is consumed.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) begin
          state_d = ST_ON;
          timer_d = ON_LOAD;
          start   = 1'b1;
        end
      end
      ST_ON: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TIMER_W'(1);
        end else begin
          state_d = ST_GAP;
          timer_d = OFF_LOAD;
        end
      end
      ST_GAP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TIMER_W'(1);
        end else if (pending_q != '0) begin
          state_d = ST_ON;
          timer_d = ON_LOAD;
          start   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Simultaneous enqueue and dequeue cancel, so a full queue loses nothing then.
  always_comb begin
    evt_q_d    = evt_in;
    evt_edge   = evt_in & ~evt_q_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    case ({evt_edge, start})
      2'b10: begin
        if (pending_q == PEND_MAX) begin
          overflow_d = 1'b1;
        end else begin
          pending_d = pending_q + PEND_W'(1);
        end
      end
      2'b01:   pending_d = pending_q - PEND_W'(1);
      default: pending_d = pending_q;
    endcase
  end

  assign led_out  = (state_q == ST_ON);
  assign busy     = (state_q != ST_IDLE);
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_led_blink_queue.sv
// Directed bench for led_blink_queue: a short-blink instance (ON=4, OFF=3) and
// a long-blink instance (ON=20, OFF=3), both with a 2-bit pending counter.
module tb_led_blink_queue;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s, evt_s, led_s, busy_s, ovf_s;
  logic [1:0] pend_s;
  logic       rst_l, evt_l, led_l, busy_l, ovf_l;
  logic [1:0] pend_l;

  int checks = 0;
  int errors = 0;

  led_blink_queue #(.ON_CYCLES(4), .OFF_CYCLES(3), .PEND_W(2)) dut_s (
    .clk(clk), .rst(rst_s), .evt_in(evt_s),
    .led_out(led_s), .busy(busy_s), .pending(pend_s), .overflow(ovf_s)
  );

  led_blink_queue #(.ON_CYCLES(20), .OFF_CYCLES(3), .PEND_W(2)) dut_l (
    .clk(clk), .rst(rst_l), .evt_in(evt_l),
    .led_out(led_l), .busy(busy_l), .pending(pend_l), .overflow(ovf_l)
  );

  typedef struct {
    logic       evt;
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < 24; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
  endtask

  // Entry i drives evt_s before edge i and holds the outputs expected after it.
  task automatic run_tbl(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      evt_s = tbl[i].evt;
      tick();
      chk($sformatf("%s e%0d led", tag, i), {31'd0, led_s}, {31'd0, tbl[i].led});
      chk($sformatf("%s e%0d busy", tag, i), {31'd0, busy_s}, {31'd0, tbl[i].busy});
      chk($sformatf("%s e%0d pend", tag, i), {30'd0, pend_s}, {30'd0, tbl[i].pend});
      chk($sformatf("%s e%0d ovf", tag, i), {31'd0, ovf_s}, {31'd0, tbl[i].ovf});
    end
    evt_s = 1'b0;
  endtask

  initial begin
    int rises, on_cnt, max_p;
    logic prev;

    rst_s = 1'b1; rst_l = 1'b1; evt_s = 1'b0; evt_l = 1'b0;
    #12;
    chk("reset led", {31'd0, led_s}, 0);
    chk("reset busy", {31'd0, busy_s}, 0);
    chk("reset pend", {30'd0, pend_s}, 0);
    chk("reset ovf", {31'd0, ovf_s}, 0);
    chk("reset long busy", {31'd0, busy_l}, 0);
    tick();
    rst_s = 1'b0; rst_l = 1'b0;

    // Single pulse at edge 10
    clear_tbl();
    tbl[10].evt = 1'b1;
    tbl[10].pend = 2'd1;
    for (int i = 11; i <= 14; i++) tbl[i].led = 1'b1;
    for (int i = 11; i <= 17; i++) tbl[i].busy = 1'b1;
    run_tbl("single", 20);

    // Level held for 20 cycles counts once
    rises = 0; on_cnt = 0; max_p = 0; prev = led_s;
    for (int i = 0; i < 40; i++) begin
      evt_s = (i < 20);
      tick();
      if (led_s && !prev) rises++;
      if (led_s) on_cnt++;
      if (int'(pend_s) > max_p) max_p = int'(pend_s);
      prev = led_s;
    end
    evt_s = 1'b0;
    chk("held blinks", rises, 1);
    chk("held on cycles", on_cnt, 4);
    chk("held max pend", max_p, 1);
    chk("held idle", {31'd0, busy_s}, 0);

    // Three pulses at edges 0, 2, 4: back-to-back blinks
    clear_tbl();
    tbl[0].evt = 1'b1; tbl[2].evt = 1'b1; tbl[4].evt = 1'b1;
    for (int i = 1; i <= 4; i++) tbl[i].led = 1'b1;
    for (int i = 8; i <= 11; i++) tbl[i].led = 1'b1;
    for (int i = 15; i <= 18; i++) tbl[i].led = 1'b1;
    for (int i = 1; i <= 21; i++) tbl[i].busy = 1'b1;
    tbl[0].pend = 2'd1; tbl[2].pend = 2'd1; tbl[3].pend = 2'd1;
    for (int i = 4; i <= 7; i++) tbl[i].pend = 2'd2;
    for (int i = 8; i <= 14; i++) tbl[i].pend = 2'd1;
    run_tbl("three", 24);

    // Async reset during the second ON phase
    for (int i = 0; i < 10; i++) begin
      evt_s = (i == 0 || i == 2 || i == 4);
      tick();
    end
    evt_s = 1'b0;
    chk("pre-rst led", {31'd0, led_s}, 1);
    chk("pre-rst pend", {30'd0, pend_s}, 1);
    #3;
    rst_s = 1'b1;
    #1;
    chk("async rst led", {31'd0, led_s}, 0);
    chk("async rst busy", {31'd0, busy_s}, 0);
    chk("async rst pend", {30'd0, pend_s}, 0);
    chk("async rst ovf", {31'd0, ovf_s}, 0);
    #2;
    rst_s = 1'b0;
    on_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (led_s || busy_s) on_cnt++;
    end
    chk("post-rst quiet", on_cnt, 0);

    // evt_in high through reset release counts as one event
    rst_s = 1'b1;
    evt_s = 1'b1;
    tick();
    #3;
    rst_s = 1'b0;
    tick();
    chk("rel e1 led", {31'd0, led_s}, 0);
    chk("rel e1 pend", {30'd0, pend_s}, 1);
    tick();
    chk("rel e2 led", {31'd0, led_s}, 1);
    chk("rel e2 pend", {30'd0, pend_s}, 0);
    on_cnt = 0; rises = 0; prev = led_s;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (led_s && !prev) rises++;
      if (led_s) on_cnt++;
      prev = led_s;
    end
    evt_s = 1'b0;
    chk("rel extra on", on_cnt, 3);
    chk("rel extra blinks", rises, 0);
    chk("rel idle", {31'd0, busy_s}, 0);
    chk("short ovf", {31'd0, ovf_s}, 0);

    // Long blinks: saturation and overflow
    rises = 0; prev = led_l;
    for (int i = 0; i < 120; i++) begin
      evt_l = (i <= 10) && (i % 2 == 0);
      tick();
      if (led_l && !prev) rises++;
      prev = led_l;
      if (i % 2 == 1 && i <= 11)
        chk($sformatf("long pend e%0d", i), {30'd0, pend_l}, (i >= 7) ? 3 : (i - 1) / 2);
      if (i == 7) chk("long ovf e7", {31'd0, ovf_l}, 0);
      if (i == 8) chk("long ovf e8", {31'd0, ovf_l}, 1);
    end
    evt_l = 1'b0;
    chk("long blinks", rises, 4);
    chk("long idle", {31'd0, busy_l}, 0);
    chk("long ovf sticky", {31'd0, ovf_l}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
